// File: rtl/alu_control_seq.sv
// ============================================================================
// Module   : alu_control_seq
// Purpose  : ALU-control decoder with valid/ready handshake and multi-cycle
//            (MUL/DIV) execute sequencing, registered outputs.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_control_seq #(
  parameter int FUNC_W    = 4,
  parameter int CTRL_W    = 3,
  parameter int MC_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [FUNC_W-1:0] func,
  input  logic              flush,
  output logic [CTRL_W-1:0] alu_control,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              mc_start,
  output logic              mc_busy,
  output logic              illegal
);

  localparam int c_cnt_w = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_mc_load = c_cnt_w'(MC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MC   = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [CTRL_W-1:0]  r_alu_control;
  logic               r_illegal;
  logic               r_out_valid;
  logic               r_mc_start;
  logic               r_mc_busy;

  logic [2:0]         w_code;
  logic               w_illegal;
  logic               w_multi;
  logic               w_in_ready;
  logic               w_xfer;

  // Combinational decode of the request currently presented.
  always_comb begin
    w_code    = 3'd0;
    w_illegal = 1'b0;
    w_multi   = 1'b0;
    unique case (alu_op)
      2'b11: w_code = 3'd0;
      2'b01: w_code = 3'd1;
      2'b10: w_illegal = 1'b1;
      default: begin
        if (func > FUNC_W'(7)) begin
          w_illegal = 1'b1;
        end else begin
          w_code  = func[2:0];
          w_multi = (func[2:1] == 2'b11);
        end
      end
    endcase
  end

  // Reset and flush both block acceptance in the same cycle they are seen.
  assign w_in_ready = rst_n && !flush &&
                      ((r_state == IDLE) || ((r_state == OUT) && out_ready));
  assign w_xfer     = in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_alu_control <= '0;
      r_illegal     <= 1'b0;
      r_out_valid   <= 1'b0;
      r_mc_start    <= 1'b0;
      r_mc_busy     <= 1'b0;
    end else begin
      r_mc_start <= 1'b0;
      if (w_xfer) begin
        r_alu_control <= CTRL_W'(w_code);
        r_illegal     <= w_illegal;
        if (w_multi) begin
          r_state     <= MC;
          r_cnt       <= c_mc_load;
          r_mc_start  <= 1'b1;
          r_mc_busy   <= 1'b1;
          r_out_valid <= 1'b0;
        end else begin
          r_state     <= OUT;
          r_cnt       <= '0;
          r_mc_busy   <= 1'b0;
          r_out_valid <= 1'b1;
        end
      end else begin
        unique case (r_state)
          MC: begin
            if (r_cnt == '0) begin
              r_state     <= OUT;
              r_mc_busy   <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          OUT: begin
            // Result is held until consumed; alu_control/illegal keep their value.
            if (out_ready) begin
              r_state     <= IDLE;
              r_out_valid <= 1'b0;
            end
          end
          default: begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_mc_busy   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign alu_control = r_alu_control;
  assign illegal     = r_illegal;
  assign out_valid   = r_out_valid;
  assign mc_start    = r_mc_start;
  assign mc_busy     = r_mc_busy;

endmodule

`default_nettype wire

// File: tb/tb_alu_control_seq.sv
// ============================================================================
// Module   : tb_alu_control_seq
// Purpose  : Directed self-checking bench for alu_control_seq.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_control_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] alu_op;
  logic [3:0] func;
  logic       flush;
  logic [2:0] alu_control;
  logic       out_valid;
  logic       out_ready;
  logic       mc_start;
  logic       mc_busy;
  logic       illegal;

  int n_checks = 0;
  int n_fail   = 0;

  alu_control_seq #(
    .FUNC_W   (4),
    .CTRL_W   (3),
    .MC_CYCLES(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .func       (func),
    .flush      (flush),
    .alu_control(alu_control),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .mc_start   (mc_start),
    .mc_busy    (mc_busy),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [2:0] ac, input logic il);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".alu_control"}, 32'(alu_control), 32'(ac));
    chk({tag, ".illegal"}, 32'(illegal), 32'(il));
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0; in_valid = 1'b0; alu_op = 2'b00; func = 4'd0;
    flush = 1'b0; out_ready = 1'b0;

    // Reset values
    tick(); tick();
    chk_out("reset", 1'b0, 3'd0, 1'b0);
    chk("reset.mc_busy", 32'(mc_busy), 32'd0);
    chk("reset.mc_start", 32'(mc_start), 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle.in_ready", 32'(in_ready), 32'd1);

    // Single-cycle R-type: func=3
    alu_op = 2'b00; func = 4'd3; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk_out("func3", 1'b1, 3'd3, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("func3.drain.out_valid", 32'(out_valid), 32'd0);

    // MUL: 16 MC cycles, result on cycle 17
    alu_op = 2'b00; func = 4'd6; in_valid = 1'b1;
    tick();
    chk("mul.c1.mc_start", 32'(mc_start), 32'd1);
    chk("mul.c1.mc_busy", 32'(mc_busy), 32'd1);
    chk("mul.c1.out_valid", 32'(out_valid), 32'd0);
    chk("mul.c1.in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    for (int i = 2; i <= 16; i++) begin
      tick();
      chk("mul.mc.mc_start", 32'(mc_start), 32'd0);
      chk("mul.mc.mc_busy", 32'(mc_busy), 32'd1);
      chk("mul.mc.out_valid", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;
    tick();
    chk_out("mul.c17", 1'b1, 3'd6, 1'b0);
    chk("mul.c17.mc_busy", 32'(mc_busy), 32'd0);

    // Stall in OUT for 5 cycles; pending ADD must not be taken
    in_valid = 1'b1; alu_op = 2'b11; func = 4'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("stall", 1'b1, 3'd6, 1'b0);
      chk("stall.in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("b2b.in_ready", 32'(in_ready), 32'd1);
    tick();
    chk_out("b2b.add", 1'b1, 3'd0, 1'b0);

    // Back-to-back decode sweep
    alu_op = 2'b10; func = 4'd5;
    tick();
    chk_out("aluop10", 1'b1, 3'd0, 1'b1);
    alu_op = 2'b00; func = 4'd5;
    tick();
    chk_out("func5", 1'b1, 3'd5, 1'b0);
    alu_op = 2'b00; func = 4'd9;
    tick();
    chk_out("func9", 1'b1, 3'd0, 1'b1);
    alu_op = 2'b01; func = 4'd9;
    tick();
    chk_out("sub", 1'b1, 3'd1, 1'b0);
    in_valid = 1'b0;
    tick();
    chk("sub.drain.out_valid", 32'(out_valid), 32'd0);

    // DIV flushed on its 4th MC cycle
    alu_op = 2'b00; func = 4'd7; in_valid = 1'b1;
    tick();
    chk("div.c1.alu_control", 32'(alu_control), 32'd7);
    chk("div.c1.mc_start", 32'(mc_start), 32'd1);
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("div.c4.mc_busy", 32'(mc_busy), 32'd1);
    flush = 1'b1;
    #1;
    chk("flush.in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    chk_out("flush", 1'b0, 3'd0, 1'b0);
    chk("flush.mc_busy", 32'(mc_busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid || mc_busy) seen = 1'b1;
    end
    chk("flush.no_div_result", 32'(seen), 32'd0);

    // Flush beats a simultaneous transfer in IDLE
    alu_op = 2'b01; in_valid = 1'b1; flush = 1'b1;
    tick();
    chk("flush_prio.out_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; in_valid = 1'b0;

    // Reset during OUT discards the result
    alu_op = 2'b00; func = 4'd2; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    chk_out("func2", 1'b1, 3'd2, 1'b0);
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    chk_out("rst_out", 1'b0, 3'd0, 1'b0);
    chk("rst_out.in_ready", 32'(in_ready), 32'd0);
    chk("rst_out.mc_busy", 32'(mc_busy), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_release.out_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
